// File: rtl/dpsk_pkg.sv
// Shared definitions for the DPSK transmit scheduler: FSM states and
// default timing parameters.
package dpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

  // 80 Hz bit rate from a 12 MHz clock.
  localparam int BIT_DIV_DEF       = 150000;
  // Carrier divider used by the downstream modulator.
  localparam int CARRIER_DIV_DEF   = 30000;
  localparam int PREAMBLE_BITS_DEF = 8;

endpackage

// File: rtl/dpsk_bit_timer.sv
// Bit-period timer: counts 0..BIT_DIV-1 while enabled, parks at 0 otherwise.
// strobe_o marks the first cycle of a bit period, last_o the final one.
module dpsk_bit_timer #(
  parameter int BIT_DIV = 150000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  output logic [$clog2(BIT_DIV)-1:0] cnt_o,
  output logic                       strobe_o,
  output logic                       last_o
);

  localparam int            CW   = $clog2(BIT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the end of a period, hold at zero when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign strobe_o = en_i && (cnt_q == '0);
  assign last_o   = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dpsk_tx_scheduler.sv
// Two-requester DPSK frame scheduler: round-robin arbiter, frame FSM
// (preamble / data / guard) and differential bit encoder.
//
// Handshake: a requester raises reqN_valid with reqN_data and holds both
// until reqN_ready. ready is a single-cycle pulse, only ever issued in IDLE,
// and the byte is captured on the same clock edge; valid seen outside IDLE
// simply waits for the next IDLE cycle.
module dpsk_tx_scheduler
  import dpsk_pkg::*;
#(
  parameter int BIT_DIV       = BIT_DIV_DEF,
  parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [7:0]                 req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [7:0]                 req1_data,
  output logic                       req1_ready,
  output logic                       tx_active,
  output logic                       grant_id,
  output logic                       bit_strobe,
  output logic                       data_bit,
  output logic                       encoded_bit,
  output logic                       frame_done,
  output logic [1:0]                 state_dbg,
  output logic [$clog2(BIT_DIV)-1:0] timer_dbg
);

  localparam int             NB        = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int             BCW       = $clog2(NB);
  localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(7);

  state_t         state_q;
  logic           last_q;      // requester granted most recently
  logic           grant_id_q;
  logic [7:0]     shreg_q;     // payload, shifted out MSB first
  logic [BCW-1:0] bit_cnt_q;   // bit index within the current state
  logic           data_bit_q;
  logic           enc_q;
  logic           ref_q;       // differential phase reference

  logic                       tmr_en;
  logic                       tmr_strobe;
  logic                       tmr_last;
  logic [$clog2(BIT_DIV)-1:0] tmr_cnt;
  logic                       pick;
  logic                       grant;
  logic                       next_bit;

  assign tmr_en = (state_q != ST_IDLE);

  dpsk_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (tmr_en),
    .cnt_o    (tmr_cnt),
    .strobe_o (tmr_strobe),
    .last_o   (tmr_last)
  );

  // Round-robin pick: on a tie serve the requester not granted last.
  always_comb begin
    pick = req1_valid;
    if (req0_valid && req1_valid) begin
      pick = ~last_q;
    end
  end

  assign grant = !rst && (state_q == ST_IDLE) && (req0_valid || req1_valid);

  // Unencoded bit for the period that starts at this strobe.
  always_comb begin
    next_bit = 1'b0;
    case (state_q)
      ST_PREAMBLE: next_bit = 1'b1;
      ST_DATA:     next_bit = shreg_q[7];
      default:     next_bit = 1'b0;
    endcase
  end

  // Frame FSM, arbiter state and bit encoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      grant_id_q <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      data_bit_q <= 1'b0;
      enc_q      <= 1'b0;
      ref_q      <= 1'b0;
    end else begin
      if (tmr_strobe) begin
        data_bit_q <= next_bit;
        enc_q      <= ref_q ^ next_bit;
        ref_q      <= ref_q ^ next_bit;
        if (state_q == ST_DATA) begin
          shreg_q <= {shreg_q[6:0], 1'b0};
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q    <= ST_PREAMBLE;
            grant_id_q <= pick;
            last_q     <= pick;
            shreg_q    <= pick ? req1_data : req0_data;
            bit_cnt_q  <= '0;
            ref_q      <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (tmr_last) begin
            if (bit_cnt_q == PRE_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tmr_last) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_GUARD;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_GUARD: begin
          if (tmr_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low for as long as rst is held.
  assign req0_ready  = grant && !pick;
  assign req1_ready  = grant && pick;
  assign tx_active   = !rst && (state_q != ST_IDLE);
  assign grant_id    = !rst && grant_id_q;
  assign bit_strobe  = !rst && tmr_strobe;
  assign data_bit    = !rst && data_bit_q;
  assign encoded_bit = !rst && enc_q;
  assign frame_done  = !rst && (state_q == ST_GUARD) && tmr_last;
  assign state_dbg   = rst ? ST_IDLE : state_q;
  assign timer_dbg   = rst ? '0 : tmr_cnt;

endmodule
